mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Bus initiator for the 8-bit tri-state synchronous memory interface (ce/oce/wre/ad/data_bus) used by the ROM/RAM blocks. It accepts single read or write requests over a valid/ready handshake and sequences the chip-enable, output-enable and write-enable strobes. It drives write data onto the shared data bus and captures read data one clock after the address is presented. It sits between the CPU-side memory request logic and one memory instance.

## Interface
- ADDR_W, 13, address width; an 8 KB bank is addressed.
- DATA_W, 8, data bus width.
- WAIT_STATES, 0, extra cycles, range 0..3, for which each address/write phase is held.

- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  input  1  1 = write, 0 = read; sampled at accept.
- req_addr  input  ADDR_W  address; sampled at accept.
- req_wdata  input  DATA_W  write data; sampled at accept.
- rsp_valid  output  1  one-cycle pulse when a transaction completes.
- rsp_rdata  output  DATA_W  read data (or verify read-back); holds until the next capture.
- rsp_err  output  1  verify mismatch; valid with rsp_valid. Constant 0 without the macro.
- ce  output  1  memory chip enable.
- oce  output  1  memory output enable.
- wre  output  1  memory write enable.
- ad  output  ADDR_W  memory address.
- data_bus  inout  DATA_W  shared bus. Driven with the latched write data exactly when the registered ce && wre is high, otherwise high-Z.

## Operation
- States: IDLE, WR, RD_ADDR, RD_DATA; with the macro also VRD_ADDR and VRD_DATA.
- IDLE:
  - ce = oce = wre = 0; bus released; ad holds its last value; req_ready = 1.
  - On accept, go to WR if req_we, otherwise RD_ADDR. Address and data are latched.
- WR:
  - ce = 1, wre = 1, oce = 0; ad = address; data_bus driven.
  - Held for 1 + WAIT_STATES cycles using a 2-bit wait counter.
  - Then go to IDLE with rsp_valid pulsed, or to VRD_ADDR with the macro.
- RD_ADDR:
  - ce = 1, oce = 1, wre = 0; held for 1 + WAIT_STATES cycles.
  - The memory registers its output on each of these edges.
  - Then go to RD_DATA.
- RD_DATA:
  - Strobes unchanged, so the memory drives the bus.
  - At the closing edge, data_bus is captured into rsp_rdata, rsp_valid is set, and the state returns to IDLE.
- All strobe, ad and bus-enable outputs are registered.
  - The master releases the bus on the same edge that the memory enable (ce && oce && !wre) can rise, so there is no contention at WR→RD turnaround.
- Requests presented while req_ready = 0 are ignored; there is no queueing.
- Back-to-back operation: the rsp_valid cycle is an IDLE cycle, so a new request may be accepted on that cycle's closing edge.

## Timing
- Let the accept edge be E0 and W = WAIT_STATES.
- Read:
  - Strobes are active from E0 to E(2+W).
  - Data is captured and rsp_valid registered at E(2+W), so rsp_valid is high in the cycle after that edge.
  - With W=0, rsp_valid is high in the 3rd cycle counting the accept cycle as cycle 0.
- Write, no macro: strobes are active from E0 to E(1+W); rsp_valid is registered at E(1+W).
- Write, with macro: the write phase (1+W cycles) is followed by a read-back phase (2+W cycles); rsp_valid is registered at E(3+2W).
- Throughput: one transaction per 3+W cycles (read), 2+W cycles (write, no macro) or 4+2W cycles (write, with macro).
- Reset (synchronous):
  - state = IDLE; ce = oce = wre = 0; ad = 0; bus high-Z; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0; err_count = 0.
  - Reset mid-transaction aborts it with no rsp_valid. The bus is released from the cycle after the reset edge. Whether the memory commits an aborted write is undefined.

## Configuration
- WRITE_VERIFY_EN defined:
  - Every write is followed by a read-back of the same address through VRD_ADDR/VRD_DATA, which mirror RD_ADDR/RD_DATA.
  - The read-back value goes to rsp_rdata.
  - rsp_err = (read-back != written data), registered with rsp_valid.
  - An output err_count [7:0] increments on each mismatch, saturates at 255, and is cleared only by reset.
- WRITE_VERIFY_EN undefined:
  - Writes complete after the write phase.
  - rsp_rdata is unchanged by writes.
  - rsp_err is tied to 0.
  - err_count and the verify states are absent.

## Test plan
- Read, W=0, memory preloaded with 0xA5 at 0x0010: accept at E0 -> ce/oce high, wre low, ad=0x0010 for 2 cycles; rsp_valid pulses once with rsp_rdata=0xA5 at E2.
- Write 0x3C to 0x1FFF, then read 0x1FFF back-to-back (second request accepted in the rsp_valid cycle) -> the read returns 0x3C; no cycle has both master and memory driving data_bus (bus never X).
- W=3 read of 0x0000 containing 0xF3 -> strobes active for 5 cycles; rsp_rdata=0xF3 at E5.
- Reset asserted in the second cycle of RD_ADDR -> no rsp_valid; next cycle ce=oce=wre=0, ad=0, bus Z, req_ready=1.
- Request held while busy (req_valid stuck at 1 with changing address) -> only the requests on req_ready cycles are executed, each exactly once.
- With WRITE_VERIFY_EN, target a write-protected/stuck memory model returning 0x00 for a write of 0x55 -> rsp_err=1, rsp_rdata=0x00, err_count=1. After 300 such writes, err_count=255.

Source files
------------

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request initiator for the 8-bit tri-state synchronous
// memory bus (ce/oce/wre/ad/data_bus). Optional write read-back verification is
// built when the macro WRITE_VERIFY_EN is defined.
module mem_bus_master #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
`ifdef WRITE_VERIFY_EN
  output logic [7:0]        err_count,
`endif
  output logic              ce,
  output logic              oce,
  output logic              wre,
  output logic [ADDR_W-1:0] ad,
  inout  wire  [DATA_W-1:0] data_bus
);

  localparam int unsigned WAIT_W = 2;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_STATES);

`ifdef WRITE_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, VRD_ADDR, VRD_DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;
`endif

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt, wait_inc;
  logic                wait_done;
  logic                bus_en, bus_en_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic                ready_nxt, ce_nxt, oce_nxt, wre_nxt;
  logic [ADDR_W-1:0]   ad_nxt;
  logic                rsp_valid_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
`ifdef WRITE_VERIFY_EN
  logic                err_nxt;
  logic [7:0]          err_count_nxt;
`endif

  assign wait_done = (wait_cnt == WAIT_LAST);
  assign wait_inc  = WAIT_W'(wait_cnt + 1'b1);

  // Master drives the bus only while its registered write strobe is up.
  assign data_bus = bus_en ? wdata_q : {DATA_W{1'bz}};

`ifndef WRITE_VERIFY_EN
  assign rsp_err = 1'b0;
`endif

  // Next-state, latched request and registered-output values.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    ad_nxt        = ad;
    wdata_nxt     = wdata_q;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata;
`ifdef WRITE_VERIFY_EN
    err_nxt       = 1'b0;
    err_count_nxt = err_count;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt = req_we ? WR : RD_ADDR;
          ad_nxt    = req_addr;
          wdata_nxt = req_wdata;
          wait_nxt  = '0;
        end
      end
      WR: begin
        if (wait_done) begin
          wait_nxt = '0;
`ifdef WRITE_VERIFY_EN
          state_nxt = VRD_ADDR;
`else
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b1;
`endif
        end else begin
          wait_nxt = wait_inc;
        end
      end
      RD_ADDR: begin
        if (wait_done) begin
          wait_nxt  = '0;
          state_nxt = RD_DATA;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      RD_DATA: begin
        rdata_nxt     = data_bus;
        rsp_valid_nxt = 1'b1;
        state_nxt     = IDLE;
      end
`ifdef WRITE_VERIFY_EN
      VRD_ADDR: begin
        if (wait_done) begin
          wait_nxt  = '0;
          state_nxt = VRD_DATA;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      VRD_DATA: begin
        rdata_nxt     = data_bus;
        rsp_valid_nxt = 1'b1;
        err_nxt       = (data_bus != wdata_q);
        if ((data_bus != wdata_q) && (err_count != 8'hFF)) begin
          err_count_nxt = err_count + 8'd1;
        end
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Strobes and bus enable are decoded from the next state so they register with it.
    ready_nxt  = (state_nxt == IDLE);
    ce_nxt     = (state_nxt != IDLE);
    wre_nxt    = (state_nxt == WR);
    oce_nxt    = ce_nxt && !wre_nxt;
    bus_en_nxt = wre_nxt;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      ce        <= 1'b0;
      oce       <= 1'b0;
      wre       <= 1'b0;
      bus_en    <= 1'b0;
      ad        <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef WRITE_VERIFY_EN
      rsp_err   <= 1'b0;
      err_count <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      req_ready <= ready_nxt;
      ce        <= ce_nxt;
      oce       <= oce_nxt;
      wre       <= wre_nxt;
      bus_en    <= bus_en_nxt;
      ad        <= ad_nxt;
      wdata_q   <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rdata_nxt;
`ifdef WRITE_VERIFY_EN
      rsp_err   <= err_nxt;
      err_count <= err_count_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: scoreboard bench for mem_bus_master with two instances,
// WAIT_STATES=0 (u_dut0) and WAIT_STATES=3 (u_dut1), each on its own memory model.
module tb_mem_bus_master;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;
  localparam int W0 = 0;
  localparam int W1 = 3;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]         req_valid, req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  wire  [1:0]         req_ready, rsp_valid, rsp_err, ce, oce, wre;
  wire  [1:0][AW-1:0] ad;
  wire  [1:0][DW-1:0] rsp_rdata;
  wire  [DW-1:0]      bus0, bus1;
`ifdef WRITE_VERIFY_EN
  wire  [1:0][7:0]    err_count;
`endif

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(W0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
`ifdef WRITE_VERIFY_EN
    .err_count(err_count[0]),
`endif
    .ce(ce[0]), .oce(oce[0]), .wre(wre[0]), .ad(ad[0]), .data_bus(bus0)
  );

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(W1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
`ifdef WRITE_VERIFY_EN
    .err_count(err_count[1]),
`endif
    .ce(ce[1]), .oce(oce[1]), .wre(wre[1]), .ad(ad[1]), .data_bus(bus1)
  );

  // Synchronous memory models: registered output data and registered output enable.
  logic [7:0] mem0 [8192];
  logic [7:0] mem1 [8192];
  logic [7:0] dout0, dout1;
  logic       oe0 = 1'b0, oe1 = 1'b0;
  logic       stuck0;

  always @(posedge clk) begin
    if (ce[0] && wre[0] && !stuck0) mem0[ad[0]] <= bus0;
    if (ce[0] && oce[0] && !wre[0]) dout0 <= stuck0 ? 8'h00 : mem0[ad[0]];
    oe0 <= !reset && ce[0] && oce[0] && !wre[0];
  end
  always @(posedge clk) begin
    if (ce[1] && wre[1]) mem1[ad[1]] <= bus1;
    if (ce[1] && oce[1] && !wre[1]) dout1 <= mem1[ad[1]];
    oe1 <= !reset && ce[1] && oce[1] && !wre[1];
  end
  assign bus0 = oe0 ? dout0 : 8'hzz;
  assign bus1 = oe1 ? dout1 : 8'hzz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_exp [2] = '{0, 0};
  int         n_rsp [2] = '{0, 0};
  logic [7:0] last_rd [2] = '{8'h00, 8'h00};
  logic [7:0] pre_val [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  exp_t       q0 [$];
  exp_t       q1 [$];
  exp_t       mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Expected rsp_rdata for a healthy write.
  function automatic logic [7:0] wexp(input int i, input logic [7:0] wd);
`ifdef WRITE_VERIFY_EN
    return wd;
`else
    return last_rd[i];
`endif
  endfunction

  // Called at the negedge preceding the accept edge.
  task automatic push_exp(input int i, input bit we, input logic [7:0] erd, input logic eerr);
    exp_t e;
    int   w;
    int   lat;
    w = (i == 0) ? W0 : W1;
`ifdef WRITE_VERIFY_EN
    lat = we ? 3 + 2 * w : 2 + w;
    last_rd[i] = erd;
`else
    lat = we ? 1 + w : 2 + w;
    if (!we) last_rd[i] = erd;
`endif
    e.rdata = erd;
    e.err   = eerr;
    e.cyc   = cyc + 1 + lat;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    n_exp[i]++;
  endtask

  task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [7:0] wd,
                       input logic [7:0] erd, input logic eerr);
    int n = 0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept%0d", i), 32'(req_ready[i]), 32'd1);
    if (req_ready[i]) push_exp(i, we, erd, eerr);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((qsize(i) != 0 || !req_ready[i]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle%0d", i), 32'(qsize(i)), 32'd0);
  endtask

  task automatic check_rsp(input int i, input exp_t e);
    chk($sformatf("rsp%0d_rdata", i), 32'(rsp_rdata[i]), 32'(e.rdata));
    chk($sformatf("rsp%0d_err", i), 32'(rsp_err[i]), 32'(e.err));
    chk($sformatf("rsp%0d_cycle", i), 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor: pops the scoreboard on every response and watches for bus contention.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (rsp_valid[0]) begin
        n_rsp[0]++;
        chk("rsp0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          mon_e = q0.pop_front();
          check_rsp(0, mon_e);
        end
      end
      if (rsp_valid[1]) begin
        n_rsp[1]++;
        chk("rsp1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          mon_e = q1.pop_front();
          check_rsp(1, mon_e);
        end
      end
      chk("contention0", 32'(ce[0] && wre[0] && oe0), 32'd0);
      chk("contention1", 32'(ce[1] && wre[1] && oe1), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    stuck0    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("rst%0d_strobes", i), 32'({ce[i], oce[i], wre[i]}), 32'd0);
      chk($sformatf("rst%0d_ad", i), 32'(ad[i]), 32'd0);
      chk($sformatf("rst%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst%0d_rdata", i), 32'(rsp_rdata[i]), 32'd0);
      chk($sformatf("rst%0d_err", i), 32'(rsp_err[i]), 32'd0);
`ifdef WRITE_VERIFY_EN
      chk($sformatf("rst%0d_err_count", i), 32'(err_count[i]), 32'd0);
`endif
    end
    reset = 1'b0;

    // W=0 read of 0x0010 holding 0xA5: strobes for two cycles, data at E2.
    issue(0, 1'b1, 13'h0010, 8'hA5, wexp(0, 8'hA5), 1'b0);
    wait_idle(0);
    issue(0, 1'b0, 13'h0010, 8'h00, 8'hA5, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("rd0_strobes", 32'({ce[0], oce[0], wre[0]}), 32'b110);
      chk("rd0_ad", 32'(ad[0]), 32'h0010);
      @(negedge clk);
    end
    chk("rd0_strobes_off", 32'({ce[0], oce[0], wre[0]}), 32'd0);
    chk("rd0_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    wait_idle(0);

    // Write 0x3C to 0x1FFF, then read it back accepted in the write's rsp_valid cycle.
    issue(0, 1'b1, 13'h1FFF, 8'h3C, wexp(0, 8'h3C), 1'b0);
    n = 0;
    while (!req_ready[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_rsp_cycle", 32'(rsp_valid[0]), 32'd1);
    issue(0, 1'b0, 13'h1FFF, 8'h00, 8'h3C, 1'b0);
    wait_idle(0);

    // W=3 read of 0x0000 holding 0xF3: strobes for five cycles, data at E5.
    issue(1, 1'b1, 13'h0000, 8'hF3, wexp(1, 8'hF3), 1'b0);
    wait_idle(1);
    issue(1, 1'b0, 13'h0000, 8'h00, 8'hF3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("rd1_strobes", 32'({ce[1], oce[1], wre[1]}), 32'b110);
      @(negedge clk);
    end
    chk("rd1_strobes_off", 32'({ce[1], oce[1], wre[1]}), 32'd0);
    wait_idle(1);

    // Reset in the second RD_ADDR cycle aborts the read without a response.
    issue(1, 1'b0, 13'h0000, 8'h00, 8'hF3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    q1.delete();
    n_exp[1]--;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    chk("abort_strobes", 32'({ce[1], oce[1], wre[1]}), 32'd0);
    chk("abort_ad", 32'(ad[1]), 32'd0);
    chk("abort_ready", 32'(req_ready[1]), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_rdata", 32'(rsp_rdata[1]), 32'd0);
    chk("abort_mem_oe", 32'(oe1), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Request held valid with a changing address: only ready-cycle requests run.
    for (int k = 0; k < 4; k++) issue(0, 1'b1, 13'h0100 + 13'(k), pre_val[k], wexp(0, pre_val[k]), 1'b0);
    wait_idle(0);
    acc = 0;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    for (int j = 0; j < 12; j++) begin
      req_addr[0] = 13'h0100 + 13'(j % 4);
      if (req_ready[0]) begin
        push_exp(0, 1'b0, pre_val[j % 4], 1'b0);
        acc++;
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("held_accepts", 32'(acc), 32'd4);
    wait_idle(0);

`ifdef WRITE_VERIFY_EN
    // Write-protected memory reads back 0x00: error flagged and counted, saturating.
    stuck0 = 1'b1;
    issue(0, 1'b1, 13'h0200, 8'h55, 8'h00, 1'b1);
    wait_idle(0);
    chk("err_count_1", 32'(err_count[0]), 32'd1);
    for (int k = 0; k < 299; k++) issue(0, 1'b1, 13'h0200, 8'h55, 8'h00, 1'b1);
    wait_idle(0);
    chk("err_count_sat", 32'(err_count[0]), 32'd255);
    stuck0 = 1'b0;
    issue(0, 1'b1, 13'h0201, 8'h5A, 8'h5A, 1'b0);
    wait_idle(0);
    chk("err_count_hold", 32'(err_count[0]), 32'd255);
`endif

    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk);
    chk("rsp_count0", 32'(n_rsp[0]), 32'(n_exp[0]));
    chk("rsp_count1", 32'(n_rsp[1]), 32'(n_exp[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
